// File: rtl/mcp3202_pkg.sv
// ============================================================================
//  Module      : mcp3202_pkg
//  Description : Shared types and constants for the MCP3202 scheduler slice.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mcp3202_pkg;

  localparam int ADC_BITS            = 12;
  localparam int c_DEF_TICK_CYCLES   = 200000;  // 100 MHz / 500 sps
  localparam int c_DEF_TIMEOUT_CYCLES = 20000;

  typedef logic [0:0] ch_t;

  typedef logic [1:0] state_t;
  localparam state_t c_ST_IDLE    = 2'd0;
  localparam state_t c_ST_START   = 2'd1;
  localparam state_t c_ST_CONVERT = 2'd2;

  // First enabled channel at or after last+1, wrapping; caller guarantees mask != 0.
  function automatic ch_t next_channel(input ch_t last, input logic [1:0] mask);
    ch_t pref;
    pref = last + 1'b1;
    if (mask[pref]) return pref;
    return ~pref;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sample_tick_gen.sv
// ============================================================================
//  Module      : sample_tick_gen
//  Description : Free-running rate counter, one-cycle tick every TICK_CYCLES.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_tick_gen #(
  parameter int TICK_CYCLES = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_enable,
  output logic o_tick
);

  localparam int c_CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TICK_CYCLES - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               w_at_last;

  assign w_at_last = (r_cnt == c_LAST);
  assign o_tick    = i_enable && w_at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_enable) begin
      r_cnt <= '0;
    end else if (w_at_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mcp3202_sample_scheduler.sv
// ============================================================================
//  Module      : mcp3202_sample_scheduler
//  Description : Round-robin MCP3202 conversion scheduler with watchdog and
//                valid/ready result register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcp3202_sample_scheduler
  import mcp3202_pkg::*;
#(
  parameter int   TICK_CYCLES    = c_DEF_TICK_CYCLES,
  parameter int   TIMEOUT_CYCLES = c_DEF_TIMEOUT_CYCLES,
  parameter logic SGL            = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [1:0]          ch_mask,
  output logic                conv_start,
  output logic                conv_odd,
  output logic                conv_sgl,
  input  logic                conv_done,
  input  logic [ADC_BITS-1:0] conv_data,
  output logic [ADC_BITS-1:0] out_data,
  output logic                out_ch,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                missed_tick,
  output logic                overrun,
  output logic                timeout,
  input  logic                clear_flags
);

  localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);

  state_t              r_state;
  logic [c_WD_W-1:0]   r_wd;
  ch_t                 r_last_ch;
  ch_t                 r_conv_odd;
  logic                r_conv_start;
  logic [ADC_BITS-1:0] r_out_data;
  ch_t                 r_out_ch;
  logic                r_out_valid;
  logic                r_missed_tick;
  logic                r_overrun;
  logic                r_timeout;

  logic w_tick;
  logic w_mask_any;
  logic w_capture;
  logic w_wd_expire;
  ch_t  w_next_ch;

  sample_tick_gen #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .i_enable (enable),
    .o_tick   (w_tick)
  );

  assign w_mask_any  = |ch_mask;
  assign w_next_ch   = next_channel(r_last_ch, ch_mask);
  assign w_capture   = (r_state == c_ST_CONVERT) && conv_done;
  // A done arriving on the final watchdog cycle still counts as a result.
  assign w_wd_expire = (r_state == c_ST_CONVERT) && !conv_done && (r_wd == c_WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_ST_IDLE;
      r_wd         <= '0;
      r_last_ch    <= 1'b1;
      r_conv_odd   <= 1'b0;
      r_conv_start <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_tick && w_mask_any) begin
            r_state      <= c_ST_START;
            r_conv_odd   <= w_next_ch;
            r_conv_start <= 1'b1;
          end
        end
        c_ST_START: begin
          r_state      <= c_ST_CONVERT;
          r_conv_start <= 1'b0;
          r_wd         <= '0;
        end
        c_ST_CONVERT: begin
          if (conv_done || w_wd_expire) begin
            r_state   <= c_ST_IDLE;
            r_last_ch <= r_conv_odd;
          end else begin
            r_wd <= r_wd + c_WD_W'(1);
          end
        end
        default: begin
          r_state      <= c_ST_IDLE;
          r_conv_start <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_ch    <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_capture && (!r_out_valid || out_ready)) begin
      r_out_data  <= conv_data;
      r_out_ch    <= r_conv_odd;
      r_out_valid <= 1'b1;
    end else if (!w_capture && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Clear is applied first so a coincident set event wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_missed_tick <= 1'b0;
      r_overrun     <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      if (clear_flags) begin
        r_missed_tick <= 1'b0;
        r_overrun     <= 1'b0;
        r_timeout     <= 1'b0;
      end
      if (w_tick && w_mask_any && (r_state != c_ST_IDLE)) r_missed_tick <= 1'b1;
      if (w_capture && r_out_valid && !out_ready)         r_overrun     <= 1'b1;
      if (w_wd_expire)                                    r_timeout     <= 1'b1;
    end
  end

  assign conv_start  = r_conv_start;
  assign conv_odd    = r_conv_odd;
  assign conv_sgl    = SGL;
  assign out_data    = r_out_data;
  assign out_ch      = r_out_ch;
  assign out_valid   = r_out_valid;
  assign missed_tick = r_missed_tick;
  assign overrun     = r_overrun;
  assign timeout     = r_timeout;

endmodule

`default_nettype wire
